// File: rtl/dm_pkg.sv
// Shared Debug Module interface types: DMI request/response payloads and the
// DTM operation encoding. The arbiter only carries these; it never decodes them.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    localparam logic [1:0] DTM_SUCCESS = 2'h0;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_arbiter_pkg.sv
// Helpers shared by the DMI arbiter and its round-robin picker.
package dmi_arbiter_pkg;

    // Modular add for indices already below n: (a + b) mod n without a divider.
    function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned n);
        int unsigned sum;
        sum = a + b;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage

// File: rtl/dmi_arbiter_if.sv
// Bundles the upstream (NumReq masters) and downstream (DM slave port) DMI
// handshakes seen by the arbiter. "slave" is the arbiter's view, "master" is
// the view of the surrounding masters plus Debug Module.
interface dmi_arbiter_if #(
    parameter int NumReq = 2
);
    // upstream side
    logic [NumReq-1:0]                clear_i;
    dm::dmi_req_t [NumReq-1:0]        req_i;
    logic [NumReq-1:0]                req_valid_i;
    logic [NumReq-1:0]                req_ready_o;
    dm::dmi_resp_t [NumReq-1:0]       resp_o;
    logic [NumReq-1:0]                resp_valid_o;
    logic [NumReq-1:0]                resp_ready_i;
    // downstream side
    dm::dmi_req_t                     dmi_req_o;
    logic                             dmi_req_valid_o;
    logic                             dmi_req_ready_i;
    dm::dmi_resp_t                    dmi_resp_i;
    logic                             dmi_resp_valid_i;
    logic                             dmi_resp_ready_o;

    modport slave (
        input  clear_i, req_i, req_valid_i, resp_ready_i,
               dmi_req_ready_i, dmi_resp_i, dmi_resp_valid_i,
        output req_ready_o, resp_o, resp_valid_o,
               dmi_req_o, dmi_req_valid_o, dmi_resp_ready_o
    );

    modport master (
        output clear_i, req_i, req_valid_i, resp_ready_i,
               dmi_req_ready_i, dmi_resp_i, dmi_resp_valid_i,
        input  req_ready_o, resp_o, resp_valid_o,
               dmi_req_o, dmi_req_valid_o, dmi_resp_ready_o
    );
endinterface

// File: rtl/dmi_arbiter_rr_pick.sv
// Combinational circular priority picker: returns the first set bit of
// `eligible` at or after `ptr`, wrapping from NumReq-1 back to 0.
module rr_pick
    import dmi_arbiter_pkg::*;
#(
    parameter int NumReq = 2,
    parameter int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] eligible,
    input  logic [IdxW-1:0]   ptr,
    output logic [IdxW-1:0]   idx,
    output logic              found
);
    // rot[k] is the eligibility of the master k positions after ptr
    logic [NumReq-1:0] rot;
    logic [IdxW-1:0]   cand [NumReq];

    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_rot
            assign cand[gi] = IdxW'(wrap_add(32'(ptr), 32'(gi), NumReq));
            assign rot[gi]  = eligible[cand[gi]];
        end
    endgenerate

    // Scan from the far end so the closest eligible master overrides the rest.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx   = cand[i];
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing one DMI slave port among NumReq DMI masters.
// One transaction outstanding at a time; the grant is locked from request
// acceptance until the downstream response handshake.
module dmi_arbiter
    import dm::*;
    import dmi_arbiter_pkg::*;
#(
    parameter int NumReq = 2,
    parameter int IdxW   = $clog2(NumReq)
) (
    input logic          clk_i,
    input logic          rst_i,
    dmi_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    arb_state_e      state_reg;
    logic [IdxW-1:0] rr_ptr_reg;
    logic [IdxW-1:0] owner_reg;
    logic            drop_reg;
    logic            dmi_req_valid_reg;
    dmi_req_t        req_reg;

    logic [NumReq-1:0] eligible;
    logic [IdxW-1:0]   pick_idx;
    logic              pick_found;
    logic              grant;
    logic              in_resp;
    logic              owner_clear;
    logic              drop_now;
    logic              resp_hs;

    assign eligible = bus.req_valid_i & ~bus.clear_i;

    rr_pick #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_pick (
        .eligible (eligible),
        .ptr      (rr_ptr_reg),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    // Grant only in IDLE; reset masks the ready so nothing is accepted while
    // the arbiter is being cleared.
    assign grant       = (state_reg == IDLE) & pick_found & ~rst_i;
    assign in_resp     = (state_reg == RESP);
    assign owner_clear = bus.clear_i[owner_reg];
    // An owner clear arriving together with the response still drops it.
    assign drop_now    = drop_reg | owner_clear;

    assign bus.dmi_resp_ready_o = in_resp & (drop_now | bus.resp_ready_i[owner_reg]);
    assign resp_hs              = bus.dmi_resp_valid_i & bus.dmi_resp_ready_o;

    assign bus.dmi_req_o       = req_reg;
    assign bus.dmi_req_valid_o = dmi_req_valid_reg;

    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_lane
            assign bus.req_ready_o[gi]  = grant & (pick_idx == IdxW'(gi));
            assign bus.resp_o[gi]       = bus.dmi_resp_i;
            assign bus.resp_valid_o[gi] = in_resp & (owner_reg == IdxW'(gi))
                                        & bus.dmi_resp_valid_i & ~drop_now;
        end
    endgenerate

    // Arbitration FSM: accept in IDLE, hold the registered request in REQ,
    // route or swallow the response in RESP, then advance the pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg         <= IDLE;
            rr_ptr_reg        <= '0;
            owner_reg         <= '0;
            drop_reg          <= 1'b0;
            dmi_req_valid_reg <= 1'b0;
            req_reg           <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (grant) begin
                        req_reg           <= bus.req_i[pick_idx];
                        owner_reg         <= pick_idx;
                        drop_reg          <= 1'b0;
                        dmi_req_valid_reg <= 1'b1;
                        state_reg         <= REQ;
                    end
                end
                REQ: begin
                    // Valid stays up even when aborted: the DM must see the
                    // transaction complete.
                    if (owner_clear) begin
                        drop_reg <= 1'b1;
                    end
                    if (bus.dmi_req_ready_i) begin
                        dmi_req_valid_reg <= 1'b0;
                        state_reg         <= RESP;
                    end
                end
                RESP: begin
                    if (owner_clear) begin
                        drop_reg <= 1'b1;
                    end
                    if (resp_hs) begin
                        rr_ptr_reg <= IdxW'(wrap_add(32'(owner_reg), 32'd1, NumReq));
                        state_reg  <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmi_arbiter.sv
// Bench for dmi_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against a transaction-level
// model of the arbitration rules.
module tb_dmi_arbiter;
    import dm::*;

    localparam int N = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmi_arbiter_if #(.NumReq(N)) bus ();

    dmi_arbiter #(.NumReq(N)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic dmi_req_t mk_req(input logic [6:0] a, input dtm_op_e op, input logic [31:0] d);
        dmi_req_t r;
        r.addr = a;
        r.op   = op;
        r.data = d;
        return r;
    endfunction

    function automatic dmi_req_t rand_req();
        return mk_req(7'($urandom), dtm_op_e'(2'($urandom)), $urandom);
    endfunction

    task automatic quiet();
        bus.clear_i          = '0;
        bus.req_valid_i      = '0;
        bus.resp_ready_i     = '0;
        bus.dmi_req_ready_i  = 1'b0;
        bus.dmi_resp_valid_i = 1'b0;
        bus.dmi_resp_i       = '0;
    endtask

    // Downstream DM and upstream sinks always ready / responding.
    task automatic dm_auto(input bit on);
        bus.dmi_req_ready_i  = on;
        bus.dmi_resp_valid_i = on;
        bus.resp_ready_i     = {N{on}};
        bus.dmi_resp_i.data  = $urandom;
        bus.dmi_resp_i.resp  = DTM_SUCCESS;
    endtask

    // ---------------- transaction-level reference model ----------------
    bit       armed  = 1'b0;
    bit       m_busy = 1'b0;   // a transaction is outstanding
    bit       m_sent = 1'b0;   // ...and the DM has accepted its request
    bit       m_drop = 1'b0;   // ...and its owner aborted it
    int       m_owner = 0;
    int       m_ptr   = 0;
    dmi_req_t m_req;
    int       model_grants[$];

    // Single compare process: expected outputs from the current transaction
    // record and inputs, then advance the record with this cycle's events.
    always @(negedge clk) begin
        int           win;
        bit           drop_now;
        logic [N-1:0] e_rdy;
        logic [N-1:0] e_rv;
        logic         e_dv;
        logic         e_drdy;
        win   = -1;
        e_rdy = '0;
        e_rv  = '0;
        if (!m_busy && !rst) begin
            for (int k = 0; k < N; k++) begin
                int n;
                n = (m_ptr + k) % N;
                if (win < 0 && bus.req_valid_i[n] && !bus.clear_i[n]) win = n;
            end
        end
        if (win >= 0) e_rdy[win] = 1'b1;
        e_dv     = m_busy && !m_sent;
        drop_now = m_busy && m_sent && (m_drop || bus.clear_i[m_owner]);
        e_drdy   = m_busy && m_sent && (drop_now || bus.resp_ready_i[m_owner]);
        if (m_busy && m_sent && !drop_now && bus.dmi_resp_valid_i) e_rv[m_owner] = 1'b1;

        if (armed) begin
            check("req_ready_o", 64'(bus.req_ready_o), 64'(e_rdy));
            check("dmi_req_valid_o", 64'(bus.dmi_req_valid_o), 64'(e_dv));
            if (e_dv) check("dmi_req_o", 64'(bus.dmi_req_o), 64'(m_req));
            check("dmi_resp_ready_o", 64'(bus.dmi_resp_ready_o), 64'(e_drdy));
            check("resp_valid_o", 64'(bus.resp_valid_o), 64'(e_rv));
            for (int i = 0; i < N; i++)
                check("resp_o_lane", 64'(bus.resp_o[i]), 64'(bus.dmi_resp_i));
        end

        if (rst) begin
            m_busy = 1'b0; m_sent = 1'b0; m_drop = 1'b0;
            m_owner = 0; m_ptr = 0; armed = 1'b1;
        end else if (!m_busy) begin
            if (win >= 0) begin
                m_busy = 1'b1; m_sent = 1'b0; m_drop = 1'b0;
                m_owner = win; m_req = bus.req_i[win];
                model_grants.push_back(win);
            end
        end else if (!m_sent) begin
            if (bus.clear_i[m_owner]) m_drop = 1'b1;
            if (bus.dmi_req_ready_i) m_sent = 1'b1;
        end else begin
            if (bus.clear_i[m_owner]) m_drop = 1'b1;
            if (bus.dmi_resp_valid_i && e_drdy) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % N;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int       g[$];
        int       base;
        dmi_req_t exp_w;

        rst = 1'b1;
        quiet();
        bus.req_i = '0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("reset_dmi_req_valid", 64'(bus.dmi_req_valid_o), 64'd0);
        check("reset_dmi_resp_ready", 64'(bus.dmi_resp_ready_o), 64'd0);
        check("reset_req_ready", 64'(bus.req_ready_o), 64'd0);
        check("reset_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        check("reset_dmi_req", 64'(bus.dmi_req_o), 64'd0);

        // Single master read
        tick();
        bus.req_valid_i[0] = 1'b1;
        bus.req_i[0] = mk_req(7'h11, DTM_READ, 32'h0);
        #1;
        check("read_grant", 64'(bus.req_ready_o), 64'b01);
        check("read_no_early_valid", 64'(bus.dmi_req_valid_o), 64'd0);
        tick();
        bus.req_valid_i[0] = 1'b0;
        bus.dmi_req_ready_i = 1'b1;
        #1;
        check("read_req_valid", 64'(bus.dmi_req_valid_o), 64'd1);
        check("read_req_addr", 64'(bus.dmi_req_o.addr), 64'h11);
        check("read_req_op", 64'(bus.dmi_req_o.op), 64'(DTM_READ));
        tick();
        bus.dmi_req_ready_i  = 1'b0;
        bus.dmi_resp_valid_i = 1'b1;
        bus.dmi_resp_i.data  = 32'h0000_0004;
        bus.dmi_resp_i.resp  = DTM_SUCCESS;
        bus.resp_ready_i     = 2'b01;
        #1;
        check("read_resp_valid", 64'(bus.resp_valid_o), 64'b01);
        check("read_resp_data", 64'(bus.resp_o[0].data), 64'h4);
        tick();
        quiet();
        #1;
        check("read_resp_done", 64'(bus.resp_valid_o), 64'd0);

        // Contention fairness from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        base = model_grants.size();
        bus.req_valid_i = 2'b11;
        bus.req_i[0] = rand_req();
        bus.req_i[1] = rand_req();
        dm_auto(1'b1);
        for (int c = 0; c < 20 && g.size() < 4; c++) begin
            #1;
            if (bus.req_ready_o != '0) g.push_back(bus.req_ready_o[1] ? 1 : 0);
            tick();
        end
        bus.req_valid_i = '0;
        repeat (3) tick();
        dm_auto(1'b0);
        for (int i = 0; i < 4; i++) begin
            check("fair_order_dut", 64'(i < g.size() ? g[i] : 99), 64'(i % 2));
            check("fair_order_model", 64'(base + i < model_grants.size() ? model_grants[base + i] : 99),
                  64'(i % 2));
        end

        // Downstream backpressure
        exp_w = mk_req(7'h10, DTM_WRITE, 32'h0000_0001);
        bus.req_valid_i = 2'b11;
        bus.req_i[0] = exp_w;
        bus.req_i[1] = mk_req(7'h20, DTM_READ, 32'h0);
        #1;
        check("bp_grant", 64'(bus.req_ready_o), 64'b01);
        tick();
        bus.req_valid_i[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_req_stable", 64'(bus.dmi_req_o), 64'(exp_w));
            check("bp_req_valid", 64'(bus.dmi_req_valid_o), 64'd1);
            check("bp_m1_not_ready", 64'(bus.req_ready_o[1]), 64'd0);
            tick();
        end
        bus.req_valid_i = '0;
        bus.dmi_req_ready_i = 1'b1;
        tick();
        dm_auto(1'b1);
        bus.dmi_req_ready_i = 1'b0;
        tick();
        quiet();
        tick();

        // Upstream response stall (pointer is 1, only master 0 requests)
        bus.req_valid_i[0] = 1'b1;
        bus.req_i[0] = rand_req();
        #1;
        check("stall_grant", 64'(bus.req_ready_o), 64'b01);
        tick();
        bus.req_valid_i = '0;
        bus.dmi_req_ready_i = 1'b1;
        tick();
        bus.dmi_req_ready_i  = 1'b0;
        bus.dmi_resp_valid_i = 1'b1;
        bus.dmi_resp_i       = '{data: 32'hCAFE_0001, resp: DTM_SUCCESS};
        bus.resp_ready_i     = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_dmi_resp_ready", 64'(bus.dmi_resp_ready_o), 64'd0);
            check("stall_resp_valid", 64'(bus.resp_valid_o), 64'b01);
            tick();
        end
        bus.resp_ready_i = 2'b01;
        #1;
        check("stall_release", 64'(bus.dmi_resp_ready_o), 64'd1);
        tick();
        quiet();
        #1;
        check("stall_done", 64'(bus.resp_valid_o), 64'd0);

        // Abort: master 1 clears while owning REQ
        tick();
        bus.req_valid_i[1] = 1'b1;
        bus.req_i[1] = mk_req(7'h05, DTM_READ, 32'h0);
        #1;
        check("abort_grant", 64'(bus.req_ready_o), 64'b10);
        tick();
        bus.req_valid_i = '0;
        bus.clear_i[1] = 1'b1;
        #1;
        check("abort_req_valid", 64'(bus.dmi_req_valid_o), 64'd1);
        tick();
        bus.clear_i = '0;
        bus.dmi_req_ready_i = 1'b1;
        #1;
        check("abort_hold_valid", 64'(bus.dmi_req_valid_o), 64'd1);
        tick();
        bus.dmi_req_ready_i  = 1'b0;
        bus.dmi_resp_valid_i = 1'b1;
        bus.dmi_resp_i.data  = 32'hDEAD_BEEF;
        #1;
        check("abort_consume", 64'(bus.dmi_resp_ready_o), 64'd1);
        check("abort_no_fwd", 64'(bus.resp_valid_o), 64'd0);
        tick();
        bus.dmi_resp_valid_i = 1'b0;
        bus.req_valid_i = 2'b11;
        #1;
        check("abort_next_grant", 64'(bus.req_ready_o), 64'b01);
        tick();
        bus.req_valid_i = '0;
        dm_auto(1'b1);
        repeat (2) tick();
        dm_auto(1'b0);
        tick();

        // Reset while in RESP (pointer is 1 before the reset)
        bus.req_valid_i[0] = 1'b1;
        bus.req_i[0] = rand_req();
        tick();
        bus.req_valid_i = '0;
        bus.dmi_req_ready_i = 1'b1;
        tick();
        bus.dmi_req_ready_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_dmi_req_valid", 64'(bus.dmi_req_valid_o), 64'd0);
        check("rst_mid_dmi_resp_ready", 64'(bus.dmi_resp_ready_o), 64'd0);
        check("rst_mid_req_ready", 64'(bus.req_ready_o), 64'd0);
        check("rst_mid_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        tick();
        bus.req_valid_i = 2'b11;
        #1;
        check("rst_mid_ptr_zero", 64'(bus.req_ready_o), 64'b01);
        tick();
        bus.req_valid_i = '0;
        dm_auto(1'b1);
        repeat (2) tick();
        dm_auto(1'b0);
        tick();

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                bus.req_valid_i[i]  = ($urandom_range(0, 9) < 6);
                bus.clear_i[i]      = ($urandom_range(0, 9) == 0);
                bus.resp_ready_i[i] = ($urandom_range(0, 9) < 7);
                bus.req_i[i]        = rand_req();
            end
            bus.dmi_req_ready_i  = ($urandom_range(0, 9) < 6);
            bus.dmi_resp_valid_i = ($urandom_range(0, 9) < 6);
            bus.dmi_resp_i.data  = $urandom;
            bus.dmi_resp_i.resp  = 2'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        quiet();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmi_arbiter.md
# dmi_arbiter

Round-robin arbiter that shares the Debug Module's single DMI slave port between `NumReq` DMI masters, e.g. the JTAG DTM (`dmi_jtag`) and a secondary debug bridge. It accepts one request at a time from the winning master, registers it, and forwards it downstream. It then routes the matching response back to the owning master only. At most one transaction is outstanding; the grant is locked from request acceptance until the response handshake completes.

## Interface
- `NumReq`, default 2: number of upstream DMI masters, minimum 2.
- `IdxW`, default `$clog2(NumReq)`: owner index width (derived, not overridden).

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high (already decided).
- `clear_i`  in  NumReq  per-master abort (the master's `dmi_clear_o`).
- `req_i`  in  NumReq×`dm::dmi_req_t`  upstream requests.
- `req_valid_i`  in  NumReq  upstream request valid.
- `req_ready_o`  out  NumReq  upstream request ready.
- `resp_o`  out  NumReq×`dm::dmi_resp_t`  upstream responses (all lanes carry the downstream payload).
- `resp_valid_o`  out  NumReq  upstream response valid.
- `resp_ready_i`  in  NumReq  upstream response ready.
- `dmi_req_o`  out  `dm::dmi_req_t`  downstream request (registered).
- `dmi_req_valid_o`  out  1  downstream request valid.
- `dmi_req_ready_i`  in  1  downstream request ready.
- `dmi_resp_i`  in  `dm::dmi_resp_t`  downstream response.
- `dmi_resp_valid_i`  in  1  downstream response valid.
- `dmi_resp_ready_o`  out  1  downstream response ready.

## Operation
- **States:** IDLE, REQ, RESP.
- **IDLE**
  - Eligible masters: `req_valid_i[n] & ~clear_i[n]`.
  - Winner: the first eligible master at or after `rr_ptr`, searching circularly with wrap from `NumReq-1` to 0.
  - `req_ready_o[winner]=1` in the same cycle; all other ready lanes are 0.
  - On that handshake:
    - latch `req_i[winner]` into `req_q`;
    - set `owner_q=winner`;
    - clear `drop_q`;
    - go to REQ.
- **REQ**
  - `dmi_req_valid_o=1` and `dmi_req_o=req_q`, both held stable until `dmi_req_ready_i`.
  - On `dmi_req_ready_i`, go to RESP.
- **RESP**
  - `resp_valid_o[owner_q] = dmi_resp_valid_i & ~drop_q`; other response valid lanes are 0.
  - `dmi_resp_ready_o = drop_q ? 1 : resp_ready_i[owner_q]`.
  - On the downstream response handshake:
    - go to IDLE;
    - set `rr_ptr = owner_q+1`, wrapping at `NumReq`.
- **Abort:** `clear_i[owner_q]` in REQ or RESP sets `drop_q`.
  - The downstream transaction still completes, so REQ must never deassert valid early.
  - The response is consumed internally and not forwarded.
- **Non-owner clears:** `clear_i` of a non-owner has no effect outside IDLE.
- **Upstream readiness:** `req_ready_o` is all-zero in REQ and RESP.
- **Downstream `op`:** passed through untouched, NOP included; the arbiter never interprets `op`.

## Timing
- **Reset values:**
  - state IDLE, `rr_ptr=0`, `owner_q=0`, `drop_q=0`, `req_q='0`;
  - outputs `dmi_req_valid_o=0`, `dmi_resp_ready_o=0`, `req_ready_o=0`, `resp_valid_o=0`.
- **Reset mid-operation:** a pending transaction is abandoned with no downstream completion. Masters and the DM share the same reset.
- **Request latency:** upstream handshake in cycle t gives `dmi_req_valid_o=1` in cycle t+1.
- **Response latency:** combinational pass-through, zero cycles; `resp_o` lanes equal `dmi_resp_i`.
- **Back-to-back throughput:** a downstream response handshake in cycle t returns to IDLE, so a new grant is possible in cycle t+1. A transaction therefore takes at least 3 cycles.
- **Arbitration corner cases:**
  - Simultaneous eligible requests in IDLE: the lowest index at or after `rr_ptr` wins.
  - A single requester wins every time with no idle penalty beyond the above.
- **Clear timing:**
  - Clear in the same cycle as a would-be grant blocks that master that cycle.
  - Clear in the same cycle as the response handshake still drops that response.

## Structure
- **Shared `dm` package (existing):** `dmi_req_t`, `dmi_resp_t`, `dtm_op_e`. The arbiter adds nothing there.
- **Local enum:** `arb_state_e` {IDLE, REQ, RESP}, kept local to the module.
- **Sub-module:** `rr_pick`, a combinational circular priority picker with inputs `eligible[NumReq]` and `ptr` and outputs `idx` and `found`. It is reusable and unit-testable.

## Test plan
- **Single master read:** master 0 sends addr 0x11, op READ. Expected:
  - `dmi_req_valid_o` one cycle after grant with addr 0x11;
  - DM returns data 0x00000004, resp SUCCESS;
  - only `resp_valid_o[0]` pulses, with data 0x4.
- **Contention fairness:** both masters hold valid from reset. Expected grant order 0,1,0,1 over four transactions, and `rr_ptr` wraps 1→0.
- **Downstream backpressure:** `dmi_req_ready_i` is held low for 5 cycles. Expected:
  - `dmi_req_o` stable (addr 0x10, data 0x00000001, op WRITE);
  - master 1's `req_ready_o` stays 0 throughout.
- **Upstream response stall:** `resp_ready_i[0]=0` for 3 cycles. Expected:
  - `dmi_resp_ready_o=0` for those cycles;
  - state stays RESP, then completes on the first ready cycle.
- **Abort:** `clear_i[1]` pulses while master 1 owns REQ. Expected:
  - the downstream request still completes;
  - `dmi_resp_ready_o=1` and `resp_valid_o[1]` never asserts;
  - the next grant goes to master 0.
- **Reset mid-transaction:** `rst_i` is asserted for 1 cycle in RESP. Expected: all outputs 0 the next cycle, state IDLE, `rr_ptr=0`.
